yacc_lookup_arbiter: RTL and testbench
======================================

// Module: yacc_lookup_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer sharing the single lookup port of the YACC compressed
//  cache (mainMod datapath) between NREQ address streams (e.g. I-trace and D-trace).
//  Accepts one address at a time, issues it to the cache and waits for completion.
//  Returns hit/miss, or timeout error, to the granted requester; keeps hit/miss stats.
// PARAMETERS
//  ADDR_W   32  address width
//  NREQ     2   number of requesters (>=2)
//  TIMEOUT  64  max WAIT cycles before error response (>=2)
//  CNT_W    32  width of hit/miss statistic counters
// PORTS
//  clock       in   1            single clock, all logic on posedge
//  reset       in   1            synchronous, active-high
//  req_valid   in   NREQ         requester i holds addr valid until accepted
//  req_addr    in   NREQ*ADDR_W  requester i address at [i*ADDR_W +: ADDR_W]
//  req_ready   out  NREQ         one-hot accept, combinational, IDLE only
//  rsp_valid   out  NREQ         one-hot 1-cycle response pulse, registered
//  rsp_hit     out  1            hit flag, qualified by any rsp_valid
//  rsp_err     out  1            timeout flag, qualified by any rsp_valid
//  cache_valid out  1            lookup request to cache
//  cache_addr  out  ADDR_W       lookup address, stable while cache_valid
//  cache_ready in   1            cache accepts lookup when high with cache_valid
//  cache_done  in   1            lookup complete, 1-cycle pulse
//  cache_hit   in   1            hit result, qualified by cache_done
//  hit_count   out  CNT_W        saturating count of hits
//  miss_count  out  CNT_W        saturating count of misses (errors not counted)
//  busy        out  1            high in ISSUE or WAIT
// BEHAVIOUR
//  Reset: state=IDLE, last_grant=NREQ-1 (requester 0 first), all outputs 0, counters 0.
//  Reset mid-transaction drops it: no rsp_valid, cache_valid low next cycle.
//  FSM IDLE -> ISSUE -> WAIT -> IDLE.
//  IDLE: search req_valid from last_grant+1 mod NREQ upward; first set bit = g.
//   req_ready[g]=1 that cycle; on edge latch req_addr[g], g->last_grant, go ISSUE.
//   No valid -> stay IDLE, req_ready=0.
//  ISSUE: cache_valid=1, cache_addr=latched addr; on cache_valid&cache_ready -> WAIT,
//   timer cleared. cache_done in ISSUE ignored (no state/counter effect).
//  WAIT: cache_valid=0. cache_done -> next cycle rsp_valid[g]=1, rsp_hit=cache_hit,
//   rsp_err=0; hit_count or miss_count +1; -> IDLE. Else timer+1; if timer==TIMEOUT-1
//   with no done -> next cycle rsp_valid[g]=1, rsp_err=1, rsp_hit=0; -> IDLE.
//   cache_done in same cycle as expiry: done wins (normal response).
//  rsp_hit/rsp_err hold 0 when no rsp_valid.
//  Latency: accept T; cache_valid T+1; with ready at T+1, WAIT from T+2; done at T+2
//   gives rsp_valid at T+3, which is also the earliest next accept (IDLE).
//  Counters saturate at all-ones; never wrap.
//  Requester changing addr while valid and not accepted is not supported.
// TESTING
//  1. Req0 addr 32'h0040_1A3C, cache_ready=1, cache_done+hit 2 cycles after accept ->
//     cache_addr=0040_1A3C for 1 cycle, rsp_valid=2'b01 1 cycle, rsp_hit=1, hit_count=1.
//  2. Both req_valid held high, cache always ready, done+miss immediately -> grants
//     0,1,0,1; after 4 responses miss_count=4, each requester got 2 rsp_valid pulses.
//  3. TIMEOUT=16, cache_done never asserted -> WAIT 16 cycles, then rsp_valid[g]
//     with rsp_err=1, counters unchanged, busy=0 next cycle.
//  4. cache_done pulsed in ISSUE while cache_ready=0, ready 3 cycles later -> no
//     response until a later done in WAIT; counters change exactly once.
//  5. CNT_W=4, 17 consecutive hits -> hit_count=4'hF, holds; miss_count=0.
//  6. Reset asserted 1 cycle during WAIT with req1 granted -> no rsp_valid, counters 0,
//     then both req_valid high -> requester 0 granted first.

Source files
------------

// File: rtl/yacc_lookup_arbiter_if.sv
// Handshake bundle between the lookup arbiter, its requesters and the YACC cache lookup port.
// The master modport is the arbiter's view; slave is the requester/cache side.
interface yacc_lookup_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int NREQ   = 2
);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        rsp_valid;
  logic                   rsp_hit;
  logic                   rsp_err;
  logic                   cache_valid;
  logic [ADDR_W-1:0]      cache_addr;
  logic                   cache_ready;
  logic                   cache_done;
  logic                   cache_hit;

  modport master (
    input  req_valid, req_addr, cache_ready, cache_done, cache_hit,
    output req_ready, rsp_valid, rsp_hit, rsp_err, cache_valid, cache_addr
  );

  modport slave (
    output req_valid, req_addr, cache_ready, cache_done, cache_hit,
    input  req_ready, rsp_valid, rsp_hit, rsp_err, cache_valid, cache_addr
  );
endinterface

// File: rtl/yacc_lookup_arbiter.sv
// Round-robin sequencer sharing the single YACC cache lookup port between NREQ address
// streams, one lookup in flight at a time, with timeout errors and saturating hit/miss stats.
module yacc_lookup_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  yacc_lookup_arbiter_if.master bus,
  output logic [CNT_W-1:0]     hit_count,
  output logic [CNT_W-1:0]     miss_count,
  output logic                 busy
);
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NREQ - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [IDX_W-1:0]  last_grant;
  logic [IDX_W-1:0]  pick;
  logic [IDX_W-1:0]  cand;
  logic              pick_found;
  logic [ADDR_W-1:0] addr_q;
  logic [TMR_W-1:0]  timer;
  logic [NREQ-1:0]   rsp_valid_q;
  logic              rsp_hit_q;
  logic              rsp_err_q;
  logic              accept;
  logic              issue_fire;
  logic              done_fire;
  logic              expire_fire;

  // Search starts just past the last winner so every stream gets a turn.
  always_comb begin
    pick_found = 1'b0;
    pick       = '0;
    cand       = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IDX_W'((int'(last_grant) + i) % NREQ);
      if (!pick_found && bus.req_valid[cand]) begin
        pick_found = 1'b1;
        pick       = cand;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state      = state;
    accept          = 1'b0;
    issue_fire      = 1'b0;
    done_fire       = 1'b0;
    expire_fire     = 1'b0;
    bus.req_ready   = '0;
    bus.cache_valid = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_found) begin
          accept        = 1'b1;
          bus.req_ready = NREQ'(1) << pick;
          next_state    = ISSUE;
        end
      end
      ISSUE: begin
        bus.cache_valid = 1'b1;
        if (bus.cache_ready) begin
          issue_fire = 1'b1;
          next_state = WAIT;
        end
      end
      WAIT: begin
        // A completion arriving on the expiry cycle still counts as a normal response.
        if (bus.cache_done) begin
          done_fire  = 1'b1;
          next_state = IDLE;
        end else if (timer == TMR_LAST) begin
          expire_fire = 1'b1;
          next_state  = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant  <= IDX_LAST;
      addr_q      <= '0;
      timer       <= '0;
      rsp_valid_q <= '0;
      rsp_hit_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      hit_count   <= '0;
      miss_count  <= '0;
    end else begin
      rsp_valid_q <= '0;
      rsp_hit_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      if (accept) begin
        last_grant <= pick;
        addr_q     <= bus.req_addr[pick*ADDR_W +: ADDR_W];
      end
      if (issue_fire) begin
        timer <= '0;
      end else if (state == WAIT) begin
        timer <= timer + TMR_W'(1);
      end
      // last_grant still names the owner of the in-flight lookup here.
      if (done_fire || expire_fire) begin
        rsp_valid_q <= NREQ'(1) << last_grant;
      end
      if (done_fire) begin
        rsp_hit_q <= bus.cache_hit;
        if (bus.cache_hit) begin
          if (hit_count != '1) begin
            hit_count <= hit_count + CNT_W'(1);
          end
        end else if (miss_count != '1) begin
          miss_count <= miss_count + CNT_W'(1);
        end
      end
      if (expire_fire) begin
        rsp_err_q <= 1'b1;
      end
    end
  end

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_hit    = rsp_hit_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.cache_addr = addr_q;
  assign busy           = (state != IDLE);

endmodule

// File: tb/tb_yacc_lookup_arbiter.sv
// Bench for yacc_lookup_arbiter: directed vector tables, hand-written multi-cycle corner
// sequences, and a randomized run against a transaction-level reference model.
module tb_yacc_lookup_arbiter;
  localparam int ADDR_W  = 32;
  localparam int NREQ    = 2;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [31:0] ADDR0 = 32'h0040_1A3C;
  localparam logic [31:0] ADDR1 = 32'h1111_2222;

  logic             clock;
  logic             reset;
  logic [CNT_W-1:0] hit_count;
  logic [CNT_W-1:0] miss_count;
  logic             busy;

  int checks = 0;
  int passes = 0;

  yacc_lookup_arbiter_if #(.ADDR_W(ADDR_W), .NREQ(NREQ)) bus ();

  yacc_lookup_arbiter #(
    .ADDR_W(ADDR_W), .NREQ(NREQ), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus),
    .hit_count(hit_count),
    .miss_count(miss_count),
    .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        first;
    logic [1:0]  rv;
    logic        crdy;
    logic        cdone;
    logic        chit;
    logic [1:0]  exp_rdy;
    logic        exp_cv;
    logic [31:0] exp_addr;
    logic [1:0]  exp_rspv;
    logic        exp_hit;
    logic        exp_err;
    logic        exp_busy;
    logic [3:0]  exp_hits;
    logic [3:0]  exp_misses;
  } vec_t;

  vec_t vecs[$];

  // reference model state
  int          m_owner;
  int          m_last;
  int          m_waited;
  bit          m_issued;
  logic [31:0] m_addr;
  int          m_hits;
  int          m_misses;
  int          m_rsp_owner;
  bit          m_rsp_hit;
  bit          m_rsp_err;
  logic [1:0]  rv;
  logic [31:0] ra [NREQ];

  int  wait_cnt;
  int  cv_cnt;
  int  rsp_cnt;
  bit  found;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic [1:0] valids, input logic crdy, input logic cdone, input logic chit);
    bus.req_valid   = valids;
    bus.cache_ready = crdy;
    bus.cache_done  = cdone;
    bus.cache_hit   = chit;
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic resetDut();
    reset = 1'b1;
    applyStimulus(2'b00, 1'b0, 1'b0, 1'b0);
    nextCycle();
    nextCycle();
    reset = 1'b0;
  endtask

  function automatic logic [15:0] observe();
    return {bus.req_ready, bus.cache_valid, bus.rsp_valid, bus.rsp_hit, bus.rsp_err,
            busy, hit_count, miss_count};
  endfunction

  task automatic addVec(input logic first, input logic [1:0] v, input logic crdy, input logic cdone,
                        input logic chit, input logic [1:0] erdy, input logic ecv, input logic [31:0] eaddr,
                        input logic [1:0] erspv, input logic ehit, input logic eerr, input logic ebusy,
                        input logic [3:0] ehits, input logic [3:0] emiss);
    vec_t t;
    t.first = first; t.rv = v; t.crdy = crdy; t.cdone = cdone; t.chit = chit;
    t.exp_rdy = erdy; t.exp_cv = ecv; t.exp_addr = eaddr; t.exp_rspv = erspv;
    t.exp_hit = ehit; t.exp_err = eerr; t.exp_busy = ebusy;
    t.exp_hits = ehits; t.exp_misses = emiss;
    vecs.push_back(t);
  endtask

  function automatic int rrPick(input logic [1:0] valids, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      int j = (last + k) % NREQ;
      if (valids[j]) return j;
    end
    return -1;
  endfunction

  // one fixed-length hit/miss transaction for requester 0; leaves the bench on the response cycle
  task automatic runOne(input logic hitv);
    applyStimulus(2'b01, 1'b1, 1'b0, 1'b0); sample(); nextCycle();
    applyStimulus(2'b00, 1'b1, 1'b0, 1'b0); sample(); nextCycle();
    applyStimulus(2'b00, 1'b1, 1'b1, hitv); sample(); nextCycle();
    applyStimulus(2'b00, 1'b1, 1'b0, 1'b0); sample();
  endtask

  task automatic modelReset();
    m_owner = -1; m_last = NREQ - 1; m_waited = 0; m_issued = 1'b0; m_addr = '0;
    m_hits = 0; m_misses = 0; m_rsp_owner = -1; m_rsp_hit = 1'b0; m_rsp_err = 1'b0;
    rv = 2'b00;
  endtask

  initial begin
    #20_000_000;
    $display("[TB] FAIL watchdog: actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    bus.req_addr = {ADDR1, ADDR0};
    applyStimulus(2'b00, 1'b0, 1'b0, 1'b0);
    nextCycle();
    resetDut();
    sample();
    checkOutput("reset_state", 64'(observe()), 64'd0);
    nextCycle();

    // single hit from requester 0, then alternating grants with immediate misses
    addVec(1, 2'b01, 1, 0, 0, 2'b01, 0, 32'h0, 2'b00, 0, 0, 0, 4'd0, 4'd0);
    addVec(0, 2'b00, 1, 0, 0, 2'b00, 1, ADDR0, 2'b00, 0, 0, 1, 4'd0, 4'd0);
    addVec(0, 2'b00, 1, 1, 1, 2'b00, 0, 32'h0, 2'b00, 0, 0, 1, 4'd0, 4'd0);
    addVec(0, 2'b00, 1, 0, 0, 2'b00, 0, 32'h0, 2'b01, 1, 0, 0, 4'd1, 4'd0);
    addVec(0, 2'b00, 1, 0, 0, 2'b00, 0, 32'h0, 2'b00, 0, 0, 0, 4'd1, 4'd0);
    addVec(1, 2'b11, 1, 1, 0, 2'b01, 0, 32'h0, 2'b00, 0, 0, 0, 4'd0, 4'd0);
    addVec(0, 2'b11, 1, 1, 0, 2'b00, 1, ADDR0, 2'b00, 0, 0, 1, 4'd0, 4'd0);
    addVec(0, 2'b11, 1, 1, 0, 2'b00, 0, 32'h0, 2'b00, 0, 0, 1, 4'd0, 4'd0);
    addVec(0, 2'b11, 1, 1, 0, 2'b10, 0, 32'h0, 2'b01, 0, 0, 0, 4'd0, 4'd1);
    addVec(0, 2'b11, 1, 1, 0, 2'b00, 1, ADDR1, 2'b00, 0, 0, 1, 4'd0, 4'd1);
    addVec(0, 2'b11, 1, 1, 0, 2'b00, 0, 32'h0, 2'b00, 0, 0, 1, 4'd0, 4'd1);
    addVec(0, 2'b11, 1, 1, 0, 2'b01, 0, 32'h0, 2'b10, 0, 0, 0, 4'd0, 4'd2);
    addVec(0, 2'b11, 1, 1, 0, 2'b00, 1, ADDR0, 2'b00, 0, 0, 1, 4'd0, 4'd2);
    addVec(0, 2'b11, 1, 1, 0, 2'b00, 0, 32'h0, 2'b00, 0, 0, 1, 4'd0, 4'd2);
    addVec(0, 2'b11, 1, 1, 0, 2'b10, 0, 32'h0, 2'b01, 0, 0, 0, 4'd0, 4'd3);
    addVec(0, 2'b11, 1, 1, 0, 2'b00, 1, ADDR1, 2'b00, 0, 0, 1, 4'd0, 4'd3);
    addVec(0, 2'b11, 1, 1, 0, 2'b00, 0, 32'h0, 2'b00, 0, 0, 1, 4'd0, 4'd3);
    addVec(0, 2'b00, 1, 1, 0, 2'b00, 0, 32'h0, 2'b10, 0, 0, 0, 4'd0, 4'd4);
    addVec(0, 2'b00, 1, 1, 0, 2'b00, 0, 32'h0, 2'b00, 0, 0, 0, 4'd0, 4'd4);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].first) begin
        bus.req_addr = {ADDR1, ADDR0};
        resetDut();
      end
      applyStimulus(vecs[i].rv, vecs[i].crdy, vecs[i].cdone, vecs[i].chit);
      sample();
      checkOutput($sformatf("vec%0d", i), 64'(observe()),
                  64'({vecs[i].exp_rdy, vecs[i].exp_cv, vecs[i].exp_rspv, vecs[i].exp_hit,
                       vecs[i].exp_err, vecs[i].exp_busy, vecs[i].exp_hits, vecs[i].exp_misses}));
      if (vecs[i].exp_cv) checkOutput($sformatf("vec%0d_addr", i), 64'(bus.cache_addr), 64'(vecs[i].exp_addr));
      nextCycle();
    end

    // timeout: cache never completes
    resetDut();
    applyStimulus(2'b10, 1'b1, 1'b0, 1'b0); sample();
    checkOutput("to_grant", 64'(bus.req_ready), 64'(2'b10));
    nextCycle();
    applyStimulus(2'b00, 1'b1, 1'b0, 1'b0); sample();
    checkOutput("to_issue", 64'(bus.cache_valid), 64'd1);
    nextCycle();
    wait_cnt = 0;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      applyStimulus(2'b00, 1'b1, 1'b0, 1'b0);
      sample();
      if (bus.rsp_valid != 2'b00) found = 1'b1;
      else begin
        if (busy && !bus.cache_valid) wait_cnt++;
        nextCycle();
      end
    end
    checkOutput("to_rsp_seen", 64'(found), 64'd1);
    checkOutput("to_wait_cycles", 64'(wait_cnt), 64'(TIMEOUT));
    checkOutput("to_rsp", 64'({bus.rsp_valid, bus.rsp_hit, bus.rsp_err, busy, hit_count, miss_count}),
                64'({2'b10, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0}));
    nextCycle();

    // completion on the expiry cycle wins over the timeout
    resetDut();
    applyStimulus(2'b01, 1'b1, 1'b0, 1'b0); sample(); nextCycle();
    applyStimulus(2'b00, 1'b1, 1'b0, 1'b0); sample(); nextCycle();
    for (int k = 0; k < TIMEOUT; k++) begin
      applyStimulus(2'b00, 1'b1, (k == TIMEOUT - 1), 1'b1);
      sample();
      nextCycle();
    end
    applyStimulus(2'b00, 1'b1, 1'b0, 1'b0); sample();
    checkOutput("race_rsp", 64'({bus.rsp_valid, bus.rsp_hit, bus.rsp_err, hit_count, miss_count}),
                64'({2'b01, 1'b1, 1'b0, 4'd1, 4'd0}));
    nextCycle();

    // done pulsed during ISSUE is ignored; only the later WAIT completion counts
    resetDut();
    cv_cnt = 0;
    rsp_cnt = 0;
    for (int k = 0; k <= 8; k++) begin
      applyStimulus((k == 0) ? 2'b01 : 2'b00, (k >= 4), (k == 1 || k == 8), (k == 1));
      sample();
      if (bus.cache_valid) cv_cnt++;
      if (bus.rsp_valid != 2'b00) rsp_cnt++;
      if (k == 4) checkOutput("issue_addr", 64'(bus.cache_addr), 64'(ADDR0));
      nextCycle();
    end
    checkOutput("issue_cv_cycles", 64'(cv_cnt), 64'd4);
    checkOutput("issue_no_early_rsp", 64'(rsp_cnt), 64'd0);
    applyStimulus(2'b00, 1'b0, 1'b0, 1'b0); sample();
    checkOutput("issue_rsp", 64'({bus.rsp_valid, bus.rsp_hit, bus.rsp_err, hit_count, miss_count}),
                64'({2'b01, 1'b0, 1'b0, 4'd0, 4'd1}));
    nextCycle();
    sample();
    checkOutput("issue_once", 64'({bus.rsp_valid, hit_count, miss_count}), 64'({2'b00, 4'd0, 4'd1}));
    nextCycle();

    // saturating hit counter
    resetDut();
    for (int k = 1; k <= CNT_MAX + 2; k++) begin
      runOne(1'b1);
      checkOutput($sformatf("sat_rsp%0d", k), 64'({bus.rsp_valid, bus.rsp_hit}), 64'({2'b01, 1'b1}));
      checkOutput($sformatf("sat_hits%0d", k), 64'(hit_count), 64'((k < CNT_MAX) ? k : CNT_MAX));
      nextCycle();
    end
    checkOutput("sat_misses", 64'(miss_count), 64'd0);

    // reset during WAIT drops the lookup and restarts the rotation at requester 0
    resetDut();
    applyStimulus(2'b10, 1'b1, 1'b0, 1'b0); sample(); nextCycle();
    applyStimulus(2'b00, 1'b1, 1'b0, 1'b0); sample(); nextCycle();
    applyStimulus(2'b00, 1'b1, 1'b1, 1'b1);
    reset = 1'b1;
    sample();
    nextCycle();
    reset = 1'b0;
    applyStimulus(2'b11, 1'b1, 1'b0, 1'b0); sample();
    checkOutput("rst_wait_drop", 64'(observe()), 64'({2'b01, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0}));
    nextCycle();
    applyStimulus(2'b00, 1'b1, 1'b0, 1'b0); sample();
    checkOutput("rst_regrant_addr", 64'({bus.cache_valid, bus.cache_addr}), 64'({1'b1, ADDR0}));
    nextCycle();

    // randomized run against the transaction model, with periodic resets
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int g;
      int dmod;
      logic crdy;
      logic cdone;
      logic chit;
      logic [1:0] exp_rdy;
      logic [1:0] exp_rspv;
      logic [15:0] expv;
      if (cyc % 500 == 0) begin
        resetDut();
        modelReset();
      end
      dmod = ((cyc / 250) % 2 == 0) ? 3 : 40;
      for (int i = 0; i < NREQ; i++) begin
        if (!rv[i] && $urandom_range(0, 2) == 0) begin
          rv[i] = 1'b1;
          ra[i] = $urandom;
        end
      end
      crdy  = 1'($urandom_range(0, 1));
      cdone = ($urandom_range(0, dmod - 1) == 0);
      chit  = 1'($urandom_range(0, 1));
      bus.req_addr = {ra[1], ra[0]};
      applyStimulus(rv, crdy, cdone, chit);
      sample();
      g = (m_owner < 0) ? rrPick(rv, m_last) : -1;
      exp_rdy  = (g >= 0) ? 2'(1 << g) : 2'b00;
      exp_rspv = (m_rsp_owner >= 0) ? 2'(1 << m_rsp_owner) : 2'b00;
      expv = {exp_rdy, (m_owner >= 0 && !m_issued), exp_rspv, m_rsp_hit, m_rsp_err,
              (m_owner >= 0), 4'(m_hits), 4'(m_misses)};
      checkOutput("rand_outputs", 64'(observe()), 64'(expv));
      if (m_owner >= 0 && !m_issued) checkOutput("rand_cache_addr", 64'(bus.cache_addr), 64'(m_addr));
      m_rsp_owner = -1;
      m_rsp_hit   = 1'b0;
      m_rsp_err   = 1'b0;
      if (m_owner < 0) begin
        if (g >= 0) begin
          m_owner  = g;
          m_last   = g;
          m_addr   = ra[g];
          m_issued = 1'b0;
          rv[g]    = 1'b0;
        end
      end else if (!m_issued) begin
        if (crdy) begin
          m_issued = 1'b1;
          m_waited = 0;
        end
      end else if (cdone) begin
        m_rsp_owner = m_owner;
        m_rsp_hit   = chit;
        if (chit) m_hits = (m_hits < CNT_MAX) ? m_hits + 1 : CNT_MAX;
        else      m_misses = (m_misses < CNT_MAX) ? m_misses + 1 : CNT_MAX;
        m_owner = -1;
      end else if (m_waited == TIMEOUT - 1) begin
        m_rsp_owner = m_owner;
        m_rsp_err   = 1'b1;
        m_owner     = -1;
      end else begin
        m_waited++;
      end
      nextCycle();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
